// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory loader and its neighbours.
package cpu_pkg;

  // Program image layout: one header byte N (word count, 1..LOADER_MAX_WORDS),
  // then 4*N data bytes with each word little-endian (first byte -> bits 7:0),
  // then one checksum byte equal to the XOR of all 4*N data bytes.
  localparam int LOADER_ADDR_W    = 7;
  localparam int LOADER_MAX_WORDS = 1 << LOADER_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs accepted image bytes into little-endian 32-bit words and keeps the running XOR.
module loader_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word,
  output logic [7:0]  checksum
);

  logic [1:0]  lane;
  logic [23:0] partial;

  // word includes the byte being accepted, so it is complete in the 4th-byte cycle
  assign word_ready = shift_en && (lane == 2'd3);
  assign word       = {byte_in, partial};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      checksum <= '0;
    end else if (clear) begin
      lane     <= '0;
      checksum <= '0;
    end else if (shift_en) begin
      lane     <= lane + 2'd1;
      checksum <= checksum ^ byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      partial <= {byte_in, partial[23:8]};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a checksummed program image into instruction RAM and holds the CPU in
// reset until a verified image is in place.
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = LOADER_ADDR_W,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  loader_state_t   state;
  logic [ADDR_W:0] n_words;
  logic [TMO_W-1:0] tmo_cnt;

  logic        xfer;
  logic        waiting;
  logic        launch;
  logic        hdr_bad;
  logic        fail;
  logic        last_word;
  logic        asm_ready;
  logic [31:0] asm_word;
  logic [7:0]  asm_sum;

  assign xfer      = byte_valid && byte_ready;
  assign waiting   = state inside {HEADER, DATA, CHECK};
  assign launch    = start && (state inside {IDLE, DONE, ERROR});
  assign hdr_bad   = (byte_in == 8'd0) || ({24'd0, byte_in} > DEPTH);
  assign last_word = (words_loaded + 1'b1) == n_words;

  // Every abort path funnels through one flag so ERROR entry is handled once
  assign fail = waiting && (xfer ? ((state == HEADER && hdr_bad) ||
                                    (state == CHECK  && byte_in != asm_sum))
                                 : (tmo_cnt == TMO_LAST));

  loader_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (launch),
    .shift_en  (xfer && state == DATA),
    .byte_in   (byte_in),
    .word_ready(asm_ready),
    .word      (asm_word),
    .checksum  (asm_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      cpu_rst_n    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      tmo_cnt      <= '0;
    end else begin
      if (waiting) begin
        tmo_cnt <= xfer ? '0 : tmo_cnt + 1'b1;
      end

      if (fail) begin
        state      <= ERROR;
        byte_ready <= 1'b0;
        busy       <= 1'b0;
        error      <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (start) begin
              state        <= HEADER;
              byte_ready   <= 1'b1;
              busy         <= 1'b1;
              cpu_rst_n    <= 1'b0;
              done         <= 1'b0;
              error        <= 1'b0;
              words_loaded <= '0;
              mem_addr     <= '0;
              tmo_cnt      <= '0;
            end
          end
          HEADER: begin
            if (xfer) begin
              n_words <= (ADDR_W + 1)'(byte_in);
              state   <= DATA;
            end
          end
          DATA: begin
            if (asm_ready) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_wren   <= 1'b1;
              mem_data   <= asm_word;
            end
          end
          WRITE: begin
            mem_wren     <= 1'b0;
            byte_ready   <= 1'b1;
            words_loaded <= words_loaded + 1'b1;
            // Address stops on the final word so a full-depth image never wraps
            if (last_word) begin
              state <= CHECK;
            end else begin
              state    <= DATA;
              mem_addr <= mem_addr + 1'b1;
            end
          end
          CHECK: begin
            if (xfer) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_rst_n  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader with a short timeout for the stall scenario.
module tb_instr_mem_loader;

  localparam int ADDR_W = 7;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int passed = 0;
  int wren_cnt = 0;

  instr_mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren === 1'b1) wren_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte and returns 1 time unit after the edge that transferred it.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 20) $display("FAIL handshake byte=%02h: byte_ready=%b, required 1 within 20 cycles", b, byte_ready);
    else passed++;
    tick();
    byte_valid = 1'b0;
  endtask

  // Sends one word LSB first with `gap` idle cycles between bytes, none after the last.
  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] tmp;
    tmp = w;
    for (int b = 0; b < 4; b++) begin
      send_byte(tmp[8*b +: 8]);
      if (b < 3) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({byte_ready, mem_wren, busy, done, error, cpu_rst_n} !== 6'b000001)
      $display("FAIL reset_ctrl: ready,wren,busy,done,error,cpu_rst_n=%b, required 000001",
               {byte_ready, mem_wren, busy, done, error, cpu_rst_n});
    else passed++;
    checks++;
    if (mem_addr !== 7'd0 || mem_data !== 32'd0 || words_loaded !== 8'd0)
      $display("FAIL reset_data: addr=%0d data=%08h words=%0d, required 0 0 0", mem_addr, mem_data, words_loaded);
    else passed++;
    rst_n = 1'b1;
    tick();
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle: ready=%b busy=%b, required 0 0", byte_ready, busy);
    else passed++;
  endtask

  task automatic test_single_word();
    int w0;
    w0 = wren_cnt;
    pulse_start();
    checks++;
    if ({busy, cpu_rst_n, byte_ready} !== 3'b101)
      $display("FAIL start_entry: busy,cpu_rst_n,ready=%b, required 101", {busy, cpu_rst_n, byte_ready});
    else passed++;
    send_byte(8'h01);
    send_word(32'h12345678, 0);
    checks++;
    if (mem_wren !== 1'b1 || mem_addr !== 7'd0 || mem_data !== 32'h12345678)
      $display("FAIL single_write: wren=%b addr=%0d data=%08h, required 1 0 12345678", mem_wren, mem_addr, mem_data);
    else passed++;
    tick();
    checks++;
    if (mem_wren !== 1'b0) $display("FAIL single_wren_len: wren=%b, required 0", mem_wren);
    else passed++;
    send_byte(8'h08);
    checks++;
    if ({done, error, busy, cpu_rst_n} !== 4'b1001 || words_loaded !== 8'd1)
      $display("FAIL single_done: done,error,busy,cpu_rst_n=%b words=%0d, required 1001 1",
               {done, error, busy, cpu_rst_n}, words_loaded);
    else passed++;
    checks++;
    if (wren_cnt - w0 !== 1) $display("FAIL single_wren_count: %0d, required 1", wren_cnt - w0);
    else passed++;
  endtask

  task automatic test_toggle_three();
    logic [31:0] words [3];
    int w0;
    words[0] = 32'hA1B2C3D4;
    words[1] = 32'h0F1E2D3C;
    words[2] = 32'h11223344;
    w0 = wren_cnt;
    pulse_start();
    send_byte(8'h03);
    tick();
    for (int w = 0; w < 3; w++) begin
      send_word(words[w], 1);
      checks++;
      if (mem_wren !== 1'b1 || mem_addr !== w[6:0] || mem_data !== words[w] || byte_ready !== 1'b0)
        $display("FAIL toggle_write%0d: wren=%b addr=%0d data=%08h ready=%b, required 1 %0d %08h 0",
                 w, mem_wren, mem_addr, mem_data, byte_ready, w, words[w]);
      else passed++;
      tick();
      checks++;
      if (mem_wren !== 1'b0 || words_loaded !== 8'(w + 1))
        $display("FAIL toggle_after%0d: wren=%b words=%0d, required 0 %0d", w, mem_wren, words_loaded, w + 1);
      else passed++;
    end
    send_byte(8'h40);
    checks++;
    if ({done, error, cpu_rst_n} !== 3'b101 || wren_cnt - w0 !== 3)
      $display("FAIL toggle_done: done,error,cpu_rst_n=%b writes=%0d, required 101 3",
               {done, error, cpu_rst_n}, wren_cnt - w0);
    else passed++;
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    send_byte(8'h01);
    send_word(32'h12345678, 0);
    tick();
    send_byte(8'h09);
    checks++;
    if ({done, error, busy, cpu_rst_n} !== 4'b0100)
      $display("FAIL bad_sum: done,error,busy,cpu_rst_n=%b, required 0100", {done, error, busy, cpu_rst_n});
    else passed++;
    repeat (3) tick();
    checks++;
    if (cpu_rst_n !== 1'b0 || error !== 1'b1)
      $display("FAIL bad_sum_hold: cpu_rst_n=%b error=%b, required 0 1", cpu_rst_n, error);
    else passed++;
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_clear: error=%b busy=%b, required 0 1", error, busy);
    else passed++;
    send_byte(8'h01);
    send_word(32'h12345678, 0);
    tick();
    send_byte(8'h08);
    checks++;
    if ({done, error, cpu_rst_n} !== 3'b101)
      $display("FAIL restart_done: done,error,cpu_rst_n=%b, required 101", {done, error, cpu_rst_n});
    else passed++;
  endtask

  task automatic test_bad_header();
    logic [7:0] hdrs [2];
    int w0;
    hdrs[0] = 8'h00;
    hdrs[1] = 8'h81;
    w0 = wren_cnt;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      send_byte(hdrs[i]);
      checks++;
      if ({done, error, busy, cpu_rst_n, byte_ready} !== 5'b01000)
        $display("FAIL bad_header_%02h: done,error,busy,cpu_rst_n,ready=%b, required 01000",
                 hdrs[i], {done, error, busy, cpu_rst_n, byte_ready});
      else passed++;
      tick();
    end
    checks++;
    if (wren_cnt - w0 !== 0) $display("FAIL bad_header_writes: %0d, required 0", wren_cnt - w0);
    else passed++;
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wren_cnt;
    pulse_start();
    send_byte(8'h02);
    send_word(32'hDEADBEEF, 0);
    repeat (8) tick();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_early: error=%b busy=%b, required 0 1", error, busy);
    else passed++;
    tick();
    checks++;
    if ({error, done, busy, cpu_rst_n} !== 4'b1000 || words_loaded !== 8'd1)
      $display("FAIL timeout_abort: error,done,busy,cpu_rst_n=%b words=%0d, required 1000 1",
               {error, done, busy, cpu_rst_n}, words_loaded);
    else passed++;
    checks++;
    if (wren_cnt - w0 !== 1) $display("FAIL timeout_writes: %0d, required 1", wren_cnt - w0);
    else passed++;
  endtask

  task automatic test_reset_mid_and_start_busy();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hBE);
    send_byte(8'hBA);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, mem_wren, busy, done, error, cpu_rst_n} !== 6'b000001 ||
        mem_addr !== 7'd0 || mem_data !== 32'd0 || words_loaded !== 8'd0)
      $display("FAIL async_reset: ctrl=%b addr=%0d data=%08h words=%0d, required 000001 0 00000000 0",
               {byte_ready, mem_wren, busy, done, error, cpu_rst_n}, mem_addr, mem_data, words_loaded);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h02);
    send_word(32'hCAFEBABE, 0);
    tick();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || words_loaded !== 8'd1 || mem_addr !== 7'd1 || byte_ready !== 1'b1)
      $display("FAIL start_busy: busy=%b words=%0d addr=%0d ready=%b, required 1 1 1 1",
               busy, words_loaded, mem_addr, byte_ready);
    else passed++;
    send_word(32'h01020304, 0);
    checks++;
    if (mem_wren !== 1'b1 || mem_addr !== 7'd1 || mem_data !== 32'h01020304)
      $display("FAIL start_busy_write: wren=%b addr=%0d data=%08h, required 1 1 01020304", mem_wren, mem_addr, mem_data);
    else passed++;
    tick();
    send_byte(8'h34);
    checks++;
    if ({done, error, cpu_rst_n} !== 3'b101 || words_loaded !== 8'd2)
      $display("FAIL start_busy_done: done,error,cpu_rst_n=%b words=%0d, required 101 2",
               {done, error, cpu_rst_n}, words_loaded);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_toggle_three();
    test_bad_checksum();
    test_bad_header();
    test_timeout();
    test_reset_mid_and_start_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
